// File: rtl/i2s_rx_deser.sv
// -----------------------------------------------------------------------------
// i2s_rx_deser
//
// I2S capture front end for two ADC data lines. The I2S bit clock, word clock
// and both data lines are oversampled in the MCLK domain. MSB-first words are
// deserialized, and one stereo frame per word-clock period (left and right for
// both lines) is presented on a valid/ready handshake.
//
// Optional build macro:
//   LEFT_JUSTIFIED_EN  when defined, the one-bit I2S delay is bypassed. The
//                      first BCLK rise after a word-clock change carries the
//                      MSB (left-justified format). When undefined, the design
//                      uses standard I2S.
//
// Ports:
//   MCLK_IN       system clock; must run at least 4x the BCLK rate
//   RST_N_IN      asynchronous active-low reset
//   I2S_BCLK_IN   I2S bit clock, asynchronous to MCLK_IN
//   I2S_WCLK_IN   I2S word clock (0 = left, 1 = right)
//   I2S_din0      serial data from ADC 0
//   I2S_din1      serial data from ADC 1
//   SAMPLE_READY  downstream accepts the held frame
//   CLR_ERR       clears OVERRUN and FRAME_ERR (a coincident set wins)
//   SAMPLE_VALID  a frame is held on CH0_L/CH0_R/CH1_L/CH1_R
//   CH0_L..CH1_R  captured two's-complement words, WIDTH bits each
//   OVERRUN       sticky: a frame completed while a frame was held and not taken
//   FRAME_ERR     sticky: short word, or slot overran SLOT_BITS
// -----------------------------------------------------------------------------
module i2s_rx_deser #(
  parameter int WIDTH       = 24,
  parameter int SLOT_BITS   = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             MCLK_IN,
  input  logic             RST_N_IN,
  input  logic             I2S_BCLK_IN,
  input  logic             I2S_WCLK_IN,
  input  logic             I2S_din0,
  input  logic             I2S_din1,
  input  logic             SAMPLE_READY,
  input  logic             CLR_ERR,
  output logic             SAMPLE_VALID,
  output logic [WIDTH-1:0] CH0_L,
  output logic [WIDTH-1:0] CH0_R,
  output logic [WIDTH-1:0] CH1_L,
  output logic [WIDTH-1:0] CH1_R,
  output logic             OVERRUN,
  output logic             FRAME_ERR
);

  localparam int CNT_W = $clog2(SLOT_BITS) + 1;

  localparam logic [1:0] ST_HUNT  = 2'd0;
  localparam logic [1:0] ST_DELAY = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_IDLE  = 2'd3;

  // Bits already captured when bit_cnt is 0. In left-justified mode, the
  // word-clock change rise itself carries the MSB.
`ifdef LEFT_JUSTIFIED_EN
  localparam int LJ_PRE = 1;
`else
  localparam int LJ_PRE = 0;
`endif

  // ---------------------------------------------------------------------------
  // Input synchronizers: {bclk, wclk, din1, din0}. All four signals travel
  // through the same depth, so they stay mutually aligned.
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic                        bclk_prev;
  logic                        bclk_s, wclk_s, din1_s, din0_s;
  logic                        bclk_rise;

  assign {bclk_s, wclk_s, din1_s, din0_s} = sync_q[SYNC_STAGES-1];
  assign bclk_rise = bclk_s & ~bclk_prev;

  // NOTE: clocked blocks use non-blocking assignments, so every flop samples
  // the values from before the edge and the shift chain cannot collapse.
  always_ff @(posedge MCLK_IN or negedge RST_N_IN) begin
    if (!RST_N_IN) begin
      sync_q    <= '0;
      bclk_prev <= 1'b0;
    end else begin
      sync_q[0] <= {I2S_BCLK_IN, I2S_WCLK_IN, I2S_din1, I2S_din0};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      bclk_prev <= bclk_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Slot framing FSM
  // ---------------------------------------------------------------------------
  logic [1:0]       state, state_d;
  logic [CNT_W-1:0] bit_cnt, cnt_d, cnt_inc;
  logic             chan, chan_d;
  logic             wclk_last, wclk_known, wclk_chg;
  logic             shift_en, store, err_set, drop_frame;
  logic [WIDTH-1:0] sreg0, sreg1, sh0, sh1;

  assign cnt_inc  = bit_cnt + CNT_W'(1);
  assign wclk_chg = bclk_rise && wclk_known && (wclk_s != wclk_last);
  assign sh0      = {sreg0[WIDTH-2:0], din0_s};
  assign sh1      = {sreg1[WIDTH-2:0], din1_s};

  // NOTE: every output of this block gets a default first, so that no path
  // leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d    = state;
    cnt_d      = bit_cnt;
    chan_d     = chan;
    shift_en   = 1'b0;
    store      = 1'b0;
    err_set    = 1'b0;
    drop_frame = 1'b0;
    if (wclk_chg) begin
      // A change before the word completed loses that word, and with it the frame.
      if (state == ST_DELAY || state == ST_SHIFT) begin
        err_set    = 1'b1;
        drop_frame = 1'b1;
      end
      chan_d = wclk_s;
      cnt_d  = '0;
`ifdef LEFT_JUSTIFIED_EN
      state_d  = ST_SHIFT;
      shift_en = 1'b1;
`else
      state_d  = ST_DELAY;
`endif
    end else if (bclk_rise) begin
      case (state)
        ST_DELAY, ST_SHIFT: begin
          shift_en = 1'b1;
          cnt_d    = cnt_inc;
          if (cnt_inc + CNT_W'(LJ_PRE) == CNT_W'(WIDTH)) begin
            store   = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_SHIFT;
          end
        end
        ST_IDLE:  cnt_d = cnt_inc;
        default:  ;
      endcase
      // A slot that outlives SLOT_BITS means the word clock was lost; re-hunt.
      if (state != ST_HUNT && cnt_inc == CNT_W'(SLOT_BITS)) begin
        err_set    = 1'b1;
        drop_frame = 1'b1;
        store      = 1'b0;
        state_d    = ST_HUNT;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Shift registers, word buffers and frame pairing
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] left0_buf, left1_buf, right0_buf, right1_buf;
  logic             left_ok, frame_pend;

  always_ff @(posedge MCLK_IN or negedge RST_N_IN) begin
    if (!RST_N_IN) begin
      state      <= ST_HUNT;
      bit_cnt    <= '0;
      chan       <= 1'b0;
      wclk_last  <= 1'b0;
      wclk_known <= 1'b0;
      sreg0      <= '0;
      sreg1      <= '0;
      left0_buf  <= '0;
      left1_buf  <= '0;
      right0_buf <= '0;
      right1_buf <= '0;
      left_ok    <= 1'b0;
      frame_pend <= 1'b0;
    end else begin
      state      <= state_d;
      bit_cnt    <= cnt_d;
      chan       <= chan_d;
      frame_pend <= 1'b0;
      if (bclk_rise) begin
        wclk_last  <= wclk_s;
        wclk_known <= 1'b1;
      end
      if (shift_en) begin
        sreg0 <= sh0;
        sreg1 <= sh1;
      end
      if (store) begin
        if (!chan) begin
          left0_buf <= sh0;
          left1_buf <= sh1;
          left_ok   <= 1'b1;
        end else begin
          // A right word only completes a frame if its left partner survived.
          right0_buf <= sh0;
          right1_buf <= sh1;
          frame_pend <= left_ok;
          left_ok    <= 1'b0;
        end
      end
      if (drop_frame) begin
        left_ok <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output handshake and sticky flags
  // ---------------------------------------------------------------------------
  logic overrun_set;
  assign overrun_set = frame_pend && SAMPLE_VALID && !SAMPLE_READY;

  always_ff @(posedge MCLK_IN or negedge RST_N_IN) begin
    if (!RST_N_IN) begin
      SAMPLE_VALID <= 1'b0;
      CH0_L        <= '0;
      CH0_R        <= '0;
      CH1_L        <= '0;
      CH1_R        <= '0;
      OVERRUN      <= 1'b0;
      FRAME_ERR    <= 1'b0;
    end else begin
      if (frame_pend && (!SAMPLE_VALID || SAMPLE_READY)) begin
        SAMPLE_VALID <= 1'b1;
        CH0_L        <= left0_buf;
        CH0_R        <= right0_buf;
        CH1_L        <= left1_buf;
        CH1_R        <= right1_buf;
      end else if (SAMPLE_VALID && SAMPLE_READY) begin
        SAMPLE_VALID <= 1'b0;
      end

      if (overrun_set)  OVERRUN <= 1'b1;
      else if (CLR_ERR) OVERRUN <= 1'b0;

      if (err_set)      FRAME_ERR <= 1'b1;
      else if (CLR_ERR) FRAME_ERR <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_rx_deser.sv
// -----------------------------------------------------------------------------
// tb_i2s_rx_deser
//
// Self-checking bench for i2s_rx_deser. It drives I2S frames at 64 BCLK per
// frame, with BCLK at 8 MCLK periods. Expected frames go into a queue when
// they are sent. The monitor pops each expected frame and compares it when the
// DUT hands a frame over.
// -----------------------------------------------------------------------------
module tb_i2s_rx_deser;

  localparam int WIDTH = 24;

`ifdef LEFT_JUSTIFIED_EN
  localparam int          OFF    = 0;
  localparam logic [23:0] A5_EXP = 24'hA5A5A5;
`else
  localparam int          OFF    = 1;
  localparam logic [23:0] A5_EXP = 24'h4B4B4A;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] l0;
    logic [WIDTH-1:0] r0;
    logic [WIDTH-1:0] l1;
    logic [WIDTH-1:0] r1;
  } frame_t;

  typedef struct {
    frame_t stim;
    bit     emit;
    frame_t exp;
  } vec_t;

  logic             mclk, rst_n, bclk, wclk, din0, din1, ready, clr;
  logic             valid, overrun, frame_err;
  logic [WIDTH-1:0] ch0_l, ch0_r, ch1_l, ch1_r;

  frame_t exp_q[$];
  vec_t   vecs[7];
  int     total = 0;
  int     bad   = 0;

  i2s_rx_deser #(.WIDTH(WIDTH), .SLOT_BITS(32), .SYNC_STAGES(2)) dut (
    .MCLK_IN      (mclk),
    .RST_N_IN     (rst_n),
    .I2S_BCLK_IN  (bclk),
    .I2S_WCLK_IN  (wclk),
    .I2S_din0     (din0),
    .I2S_din1     (din1),
    .SAMPLE_READY (ready),
    .CLR_ERR      (clr),
    .SAMPLE_VALID (valid),
    .CH0_L        (ch0_l),
    .CH0_R        (ch0_r),
    .CH1_L        (ch1_l),
    .CH1_R        (ch1_r),
    .OVERRUN      (overrun),
    .FRAME_ERR    (frame_err)
  );

  initial begin
    mclk = 1'b0;
    forever #20 mclk = ~mclk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic bit_at(input logic [WIDTH-1:0] word, input int off, input int p);
    if (p >= off && p < off + WIDTH) return word[WIDTH-1-(p-off)];
    return 1'b0;
  endfunction

  // One BCLK period: data and word clock change while BCLK is low.
  task automatic send_bit(input logic w, input logic d0, input logic d1);
    bclk = 1'b0; wclk = w; din0 = d0; din1 = d1;
    #160;
    bclk = 1'b1;
    #160;
  endtask

  task automatic send_slot(input logic w, input logic [WIDTH-1:0] w0,
                           input logic [WIDTH-1:0] w1, input int off, input int nbits);
    for (int p = 0; p < nbits; p++) begin
      send_bit(w, bit_at(w0, off, p), bit_at(w1, off, p));
    end
  endtask

  task automatic send_frame(input frame_t f, input int off);
    send_slot(1'b0, f.l0, f.l1, off, 32);
    send_slot(1'b1, f.r0, f.r1, off, 32);
  endtask

  task automatic set_ready(input logic v);
    @(posedge mclk); #1;
    ready = v;
  endtask

  task automatic pulse_clr();
    @(posedge mclk); #1;
    clr = 1'b1;
    @(posedge mclk); #1;
    clr = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge mclk);
    check(name, exp_q.size(), 0);
  endtask

  // Scoreboard monitor: a handshake happens on the next rising edge whenever
  // valid && ready hold at the falling edge.
  always @(negedge mclk) begin
    if (rst_n && valid && ready) begin
      if (exp_q.size() == 0) begin
        check("extra_frame", 1, 0);
      end else begin
        frame_t e;
        e = exp_q.pop_front();
        check("ch0_l", ch0_l, e.l0);
        check("ch0_r", ch0_r, e.r0);
        check("ch1_l", ch1_l, e.l1);
        check("ch1_r", ch1_r, e.r1);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t fa, fb, fc, fd, fe, fg, fz;

    rst_n = 1'b0; bclk = 1'b0; wclk = 1'b0; din0 = 1'b0; din1 = 1'b0;
    ready = 1'b1; clr = 1'b0;

    vecs[0].stim = '{l0: 24'h800001, r0: 24'h7FFFFE, l1: 24'h123456, r1: 24'hFEDCBA};
    vecs[0].emit = 1'b1;
    vecs[0].exp  = vecs[0].stim;
    for (int i = 1; i < 7; i++) begin
      vecs[i].stim = '{l0: 24'(i), r0: 24'(i + 1), l1: 24'(i), r1: 24'(i + 1)};
      vecs[i].emit = 1'b1;
      vecs[i].exp  = vecs[i].stim;
    end

    // Reset state
    #107;
    check("rst_valid", valid, 0);
    check("rst_ch0_l", ch0_l, 0);
    check("rst_ch1_r", ch1_r, 0);
    check("rst_overrun", overrun, 0);
    check("rst_frame_err", frame_err, 0);
    rst_n = 1'b1;

    // Start-up partial frame: it must never reach the output.
    send_slot(1'b0, 24'hFFFFFF, 24'hFFFFFF, OFF, 20);
    send_slot(1'b1, 24'h55AA55, 24'h55AA55, OFF, 32);

    // First clean frame and the sawtooth, with READY held high.
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].emit) exp_q.push_back(vecs[i].exp);
      send_frame(vecs[i].stim, OFF);
    end
    wait_drain("stream_drain");
    check("stream_overrun", overrun, 0);
    check("stream_frame_err", frame_err, 0);

    // Overrun: two frames with READY low; the first frame is held.
    fa = '{l0: 24'h111111, r0: 24'h222222, l1: 24'h333333, r1: 24'h444444};
    fb = '{l0: 24'hAAAAAA, r0: 24'hBBBBBB, l1: 24'hCCCCCC, r1: 24'hDDDDDD};
    set_ready(1'b0);
    exp_q.push_back(fa);
    send_frame(fa, OFF);
    send_frame(fb, OFF);
    check("ovr_valid", valid, 1);
    check("ovr_hold_l0", ch0_l, fa.l0);
    check("ovr_hold_r1", ch1_r, fa.r1);
    check("ovr_flag", overrun, 1);
    pulse_clr();
    check("ovr_cleared", overrun, 0);
    check("ovr_still_valid", valid, 1);
    set_ready(1'b1);
    wait_drain("ovr_drain");

    // Short left slot: frame error, and no frame for that period.
    send_slot(1'b0, 24'h0F0F0F, 24'h0F0F0F, OFF, 20);
    send_slot(1'b1, 24'hF0F0F0, 24'hF0F0F0, OFF, 32);
    check("ferr_flag", frame_err, 1);
    check("ferr_no_valid", valid, 0);
    pulse_clr();
    check("ferr_cleared", frame_err, 0);
    fc = '{l0: 24'h0ABCDE, r0: 24'hF54321, l1: 24'h13579B, r1: 24'h2468AC};
    exp_q.push_back(fc);
    send_frame(fc, OFF);
    wait_drain("ferr_recover");
    check("ferr_stays_clear", frame_err, 0);

    // Asynchronous reset in the middle of a right slot while a frame is held.
    fd = '{l0: 24'h5A5A5A, r0: 24'hA5A5A5, l1: 24'h5A5A5A, r1: 24'hA5A5A5};
    fe = '{l0: 24'h777777, r0: 24'h888888, l1: 24'h999999, r1: 24'h666666};
    set_ready(1'b0);
    send_frame(fd, OFF);
    check("rst2_pre_valid", valid, 1);
    send_slot(1'b0, fe.l0, fe.l1, OFF, 32);
    send_slot(1'b1, fe.r0, fe.r1, OFF, 10);
    #13 rst_n = 1'b0;
    #1;
    check("rst2_valid", valid, 0);
    check("rst2_ch0_l", ch0_l, 0);
    check("rst2_ch0_r", ch0_r, 0);
    #26 rst_n = 1'b1;
    set_ready(1'b1);
    send_slot(1'b1, fe.r0, fe.r1, OFF, 22);
    fg = '{l0: 24'hC0FFEE, r0: 24'hBEEF01, l1: 24'hDEAD02, r1: 24'hFACE03};
    exp_q.push_back(fg);
    send_frame(fg, OFF);
    wait_drain("rst2_recover");

    // MSB driven on the word-clock change rise (left-justified stimulus).
    fz = '{l0: 24'hA5A5A5, r0: 24'h000000, l1: 24'hA5A5A5, r1: 24'h000000};
    exp_q.push_back('{l0: A5_EXP, r0: 24'h000000, l1: A5_EXP, r1: 24'h000000});
    send_frame(fz, 0);
    wait_drain("lj_drain");

    repeat (20) @(negedge mclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2s_rx_deser.md
Name: i2s_rx_deser

Overview:
- I2S capture front end for the two ADC data lines I2S_din0 and I2S_din1.
- Oversamples the I2S bit clock, word clock and data lines in the MCLK domain and deserializes MSB-first words.
- Presents one stereo frame per word-clock period (left and right for both lines) on a valid/ready handshake to the downstream filter/USB stage.
- Sits directly downstream of the I2S clock generator, consuming the I2S_BCLK_OUT/I2S_WCLK_OUT that main drives to the ADCs.

Parameters:
- WIDTH, 24, bits per audio word; also the width of each sample output.
- SLOT_BITS, 32, maximum BCLK periods per channel slot; sizes the bit counter, which is clog2(SLOT_BITS)+1 bits.
- SYNC_STAGES, 2, number of synchronizer flops on each I2S input (minimum 2).

Ports:
- MCLK_IN  in  1  system clock, 24.576 MHz; must be at least 4x the BCLK frequency.
- RST_N_IN  in  1  asynchronous, active-low reset.
- I2S_BCLK_IN  in  1  I2S bit clock, asynchronous to MCLK_IN.
- I2S_WCLK_IN  in  1  I2S word clock; 0 = left, 1 = right.
- I2S_din0  in  1  serial data, ADC 0.
- I2S_din1  in  1  serial data, ADC 1.
- SAMPLE_READY  in  1  downstream accepts the frame.
- CLR_ERR  in  1  clears the sticky error flags.
- SAMPLE_VALID  out  1  frame held on the sample outputs.
- CH0_L, CH0_R, CH1_L, CH1_R  out  WIDTH  captured words, two's complement, MSB-first on the wire.
- OVERRUN  out  1  sticky: a frame completed while SAMPLE_VALID was high and not accepted.
- FRAME_ERR  out  1  sticky: a word clock edge arrived before WIDTH bits were captured.

Behaviour:
- Reset: all outputs 0; synchronizers cleared; FSM in HUNT. Reset asserted mid-frame discards the partial frame and any pending output frame.
- Input conditioning: BCLK, WCLK and both DIN lines each pass through SYNC_STAGES flops. A BCLK rising edge is detected as a one-MCLK-cycle strobe (previous=0, current=1). All sampling happens only on that strobe.
- FSM states: HUNT, DELAY, SHIFT, IDLE_SLOT.
  - HUNT: wait for the first WCLK change seen at a BCLK rise, then go to DELAY. Data is ignored before this point, so the start-up partial word is never emitted.
  - DELAY: one BCLK rise for the I2S 1-bit delay, then go to SHIFT with bit count 0.
  - SHIFT: on each BCLK rise, shift DIN into the channel shift register LSB-side, so the first bit ends up as the MSB. When the count reaches WIDTH, store the word and go to IDLE_SLOT.
  - IDLE_SLOT: ignore the remaining slot bits.
- WCLK change seen at a BCLK rise (in SHIFT or IDLE_SLOT): latch the new channel and go to DELAY.
  - If this happens in SHIFT with count < WIDTH, set FRAME_ERR and discard that word.
  - A frame that lost its word is not emitted.
- If the bit counter reaches SLOT_BITS without a WCLK change, set FRAME_ERR and return to HUNT.
- Frame completion: the right word is stored while the left word of the same frame is valid.
  - Next MCLK cycle: CH*_L/CH*_R update and SAMPLE_VALID rises.
  - Latency: 2 MCLK cycles from the BCLK strobe of the last right-channel bit, plus the synchronizer delay.
- Handshake: SAMPLE_VALID stays high and the outputs stay stable until a cycle with SAMPLE_VALID && SAMPLE_READY. SAMPLE_VALID drops on the following cycle unless a new frame completes in that same cycle; then the new frame loads and SAMPLE_VALID stays high.
- Overrun: a frame completes while SAMPLE_VALID=1 and SAMPLE_READY=0.
  - The new frame is dropped and OVERRUN is set.
  - The held frame is preserved.
- Sticky flags: CLR_ERR clears both flags. If a set event coincides with CLR_ERR, the set wins.

Optional Feature:
- Macro: LEFT_JUSTIFIED_EN.
- Defined: the DELAY state is bypassed. The first BCLK rise after the WCLK change is the MSB (left-justified format).
- Undefined: standard I2S with the 1-bit delay. All other behaviour is identical.

Test Plan:
- Reset release, BCLK=3.072 MHz, 64 BCLK/frame, din0 L=24'h800001, R=24'h7FFFFE -> the first partial frame after reset is not emitted; the next frame gives CH0_L=800001, CH0_R=7FFFFE, SAMPLE_VALID=1; OVERRUN=0, FRAME_ERR=0.
- Sawtooth L=n, R=n+1 on both lines, SAMPLE_READY held 1 -> exactly one SAMPLE_VALID per WCLK period; CH0 and CH1 values match, increment by 1 per frame, and none are missed.
- SAMPLE_READY held 0 across two frames -> the first frame is held stable and OVERRUN=1; CLR_ERR then clears it; raising READY returns the first frame's values.
- WCLK toggled after only 20 BCLKs in a left slot -> FRAME_ERR=1, no frame emitted for that period; the next clean frame is received correctly.
- RST_N_IN pulsed low in mid-right-slot with VALID=1 -> outputs are 0 immediately (asynchronous); the block re-hunts and the first complete frame after the next WCLK edge is correct.
- LEFT_JUSTIFIED_EN defined, MSB driven in the first bit after the WCLK edge, word 24'hA5A5A5 -> CH0_L=A5A5A5; the same stimulus with the macro undefined yields 24'h4B4B4A (the word is captured one bit late, so the bit following the word becomes the LSB).
